// File: rtl/mini_mips_pkg.sv
// Shared definitions for the Mini MIPS instruction-memory loader.
// Holds the memory geometry and the loader FSM state encoding.
package mini_mips_pkg;
  localparam int IMEM_DEPTH  = 1024;
  localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into one big-endian 32-bit word.
// word and word_done are valid in the same cycle the 4th byte is accepted.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic        word_done,
  output logic [31:0] word
);
  logic [1:0]  cnt_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= 2'd0;
      shift_reg <= 24'd0;
    end else if (accept) begin
      cnt_reg   <= cnt_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_data};
    end
  end

  // The incoming byte completes the word combinationally so the FSM
  // can register the write on the very edge that accepts it.
  assign word_done = accept && (cnt_reg == 2'd3);
  assign word      = {shift_reg, byte_data};
endmodule

// File: rtl/imem_loader.sv
// Framed program loader: COUNT, N data words, XOR CHECK; writes words into
// instruction memory and releases the core only after a verified image.
module imem_loader
  import mini_mips_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_error
);
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t   state_reg;
  logic [ADDR_W:0] idx_reg;
  logic [ADDR_W:0] last_idx_reg;
  logic [31:0]     acc_reg;
  logic            accept;
  logic            word_done;
  logic [31:0]     word;

  assign accept = byte_valid && byte_ready;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .byte_data (byte_data),
    .word_done (word_done),
    .word      (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_COUNT;
      idx_reg      <= '0;
      last_idx_reg <= '0;
      acc_reg      <= 32'd0;
      byte_ready   <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_run      <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_reg)
        S_COUNT: begin
          if (word_done) begin
            if (word > DEPTH) begin
              state_reg  <= S_ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else if (word == 32'd0) begin
              acc_reg   <= 32'd0;
              state_reg <= S_CHECK;
            end else begin
              // Storing N-1 keeps the end-of-data test a plain equality.
              last_idx_reg <= word[ADDR_W:0] - IDX_ONE;
              idx_reg      <= '0;
              acc_reg      <= 32'd0;
              state_reg    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (word_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= idx_reg[ADDR_W-1:0];
            imem_wdata <= word;
            acc_reg    <= acc_reg ^ word;
            idx_reg    <= idx_reg + IDX_ONE;
            if (idx_reg == last_idx_reg) begin
              state_reg <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (word_done) begin
            byte_ready <= 1'b0;
            if (word == acc_reg) begin
              state_reg <= S_DONE;
              cpu_run   <= 1'b1;
            end else begin
              state_reg  <= S_ERROR;
              load_error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          byte_ready <= 1'b0;
          cpu_run    <= 1'b1;
        end
        S_ERROR: begin
          byte_ready <= 1'b0;
          cpu_run    <= 1'b0;
          load_error <= 1'b1;
        end
        default: begin
          state_reg  <= S_ERROR;
          byte_ready <= 1'b0;
          load_error <= 1'b1;
        end
      endcase
    end
  end
endmodule
